// File: rtl/mole_pkg.sv
// Shared types, level tables and helpers for the multi-hole mole spawner.
package mole_pkg;

    typedef enum logic [1:0] {L0, L1, L2, L3} level_t;

    typedef enum logic [1:0] {IDLE, LOAD, WAIT, PICK} state_t;

    localparam int unsigned INTERVAL [4] = '{1500, 1000, 600, 300};
    localparam int unsigned LIFE     [4] = '{2000, 1400, 900, 500};

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    function automatic int unsigned popcount(input logic [31:0] v);
        int unsigned c;
        c = 0;
        for (int k = 0; k < 32; k++) begin
            c += 32'(v[k]);
        end
        return c;
    endfunction

endpackage

// File: rtl/mole_lfsr16.sv
// 16-bit Galois LFSR (taps 16,14,13,11) with XOR perturbation input.
module mole_lfsr16
    import mole_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] perturb,
    output logic [15:0] value
);

    logic [15:0] step;
    logic [15:0] nxt;

    always_comb begin
        step = {1'b0, value[15:1]} ^ (value[0] ? 16'hB400 : 16'h0000);
        nxt  = step ^ perturb;
        // perturbation could cancel the state to zero; recover from the seed
        if (nxt == 16'h0000) begin
            nxt = LFSR_SEED;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= LFSR_SEED;
        end else begin
            value <= nxt;
        end
    end

endmodule

// File: rtl/mole_spawner_multi.sv
// Multi-hole mole spawner with per-hole lifetimes and hit/expiry reporting.
// Optional MOLE_SPAWNER_WRONG_HIT_EN: wrong-hole pulse and hit-driven LFSR entropy.
module mole_spawner_multi
    import mole_pkg::*;
#(
    parameter int          N_HOLES     = 18,
    parameter int          MAX_ACTIVE  = 4,
    parameter int          TICK_DIV    = 50000,
    parameter int          MAX_MS      = 2047,
    parameter int unsigned JITTER_MASK = 'h1FF
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           enable,
    input  logic [1:0]                     level,
    input  logic [N_HOLES-1:0]             hit,
    output logic [N_HOLES-1:0]             moles,
    output logic [$clog2(N_HOLES+1)-1:0]   active_count,
    output logic                           hit_pulse,
    output logic [$clog2(N_HOLES+1)-1:0]   hit_count,
    output logic                           expire_pulse,
    output logic                           wrong_pulse,
    output logic [$clog2(MAX_MS+1)-1:0]    spawn_ms
);

    localparam int W    = $clog2(MAX_MS + 1);
    localparam int CW   = $clog2(N_HOLES + 1);
    localparam int PW   = $clog2(TICK_DIV);
    localparam int NW   = $clog2(N_HOLES);

    function automatic logic [W-1:0] sat(input int unsigned v);
        return (v > MAX_MS) ? W'(MAX_MS) : W'(v);
    endfunction

    level_t             lvl;
    state_t             state;
    logic [PW-1:0]      pre;
    logic               tick;
    logic [15:0]        lfsr;
    logic [15:0]        perturb;
    logic [NW-1:0]      cand;
    logic [CW-1:0]      probes;
    logic [N_HOLES-1:0] spawn_vec;
    logic [N_HOLES-1:0] expire_vec;
    logic [N_HOLES-1:0] hit_vec;
    logic [W-1:0]       life_ld;

    assign lvl          = level_t'(level);
    assign tick         = (pre == PW'(TICK_DIV - 1));
    assign life_ld      = sat(LIFE[lvl]);
    assign active_count = CW'(popcount(32'(moles)));
    assign hit_vec      = hit & moles;
    assign spawn_vec    = (enable && state == PICK && !moles[cand]) ?
                          (N_HOLES'(1) << cand) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre <= '0;
        end else begin
            pre <= tick ? '0 : pre + PW'(1);
        end
    end

    mole_lfsr16 u_lfsr (
        .clk     (clk),
        .rst_n   (rst_n),
        .perturb (perturb),
        .value   (lfsr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            spawn_ms <= '0;
            cand     <= '0;
            probes   <= '0;
        end else if (!enable) begin
            state <= IDLE;
        end else begin
            unique case (state)
                IDLE: state <= LOAD;
                LOAD: begin
                    spawn_ms <= sat(INTERVAL[lvl] + (32'(lfsr) & JITTER_MASK));
                    state    <= WAIT;
                end
                WAIT: begin
                    if (spawn_ms == '0) begin
                        if (32'(active_count) < MAX_ACTIVE) begin
                            cand   <= NW'(32'(lfsr) % 32'(N_HOLES));
                            probes <= '0;
                            state  <= PICK;
                        end else begin
                            state <= LOAD;
                        end
                    end else if (tick) begin
                        spawn_ms <= spawn_ms - W'(1);
                    end
                end
                PICK: begin
                    if (!moles[cand]) begin
                        state <= LOAD;
                    end else begin
                        cand   <= (cand == NW'(N_HOLES - 1)) ? '0 : cand + NW'(1);
                        probes <= probes + CW'(1);
                        if (probes == CW'(N_HOLES - 1)) begin
                            state <= LOAD;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < N_HOLES; i++) begin : g_hole
        logic         lit;
        logic [W-1:0] life;

        // spawn beats a same-cycle hit; a hit beats a same-cycle expiry
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                lit  <= 1'b0;
                life <= '0;
            end else if (!enable) begin
                lit <= 1'b0;
            end else if (spawn_vec[i]) begin
                lit  <= 1'b1;
                life <= life_ld;
            end else if (lit) begin
                if (hit[i] || life == '0) begin
                    lit <= 1'b0;
                end else if (tick) begin
                    life <= life - W'(1);
                end
            end
        end

        assign moles[i]      = lit;
        assign expire_vec[i] = lit && !hit[i] && (life == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_pulse    <= 1'b0;
            hit_count    <= '0;
            expire_pulse <= 1'b0;
        end else begin
            hit_pulse    <= enable && (|hit_vec);
            hit_count    <= enable ? CW'(popcount(32'(hit_vec))) : '0;
            expire_pulse <= enable && (|expire_vec);
        end
    end

`ifdef MOLE_SPAWNER_WRONG_HIT_EN
    logic [31:0] hit32;

    assign hit32   = 32'(hit);
    assign perturb = hit32[15:0] ^ hit32[31:16];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrong_pulse <= 1'b0;
        end else begin
            wrong_pulse <= enable && (|(hit & ~moles));
        end
    end
`else
    assign perturb     = '0;
    assign wrong_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_mole_spawner_multi.sv
// Directed bench for mole_spawner_multi: 2 holes, 2 active, 4-cycle tick, no jitter.
module tb_mole_spawner_multi;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [1:0]  level = 2'd0;
    logic [1:0]  hit = 2'b00;
    logic [1:0]  moles;
    logic [1:0]  active_count;
    logic        hit_pulse;
    logic [1:0]  hit_count;
    logic        expire_pulse;
    logic        wrong_pulse;
    logic [10:0] spawn_ms;

    int total = 0;
    int bad = 0;
    int n;
    int el;
    logic [1:0] m1;

    always #5 clk = ~clk;

    mole_spawner_multi #(
        .N_HOLES     (2),
        .MAX_ACTIVE  (2),
        .TICK_DIV    (4),
        .MAX_MS      (2047),
        .JITTER_MASK (0)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .level        (level),
        .hit          (hit),
        .moles        (moles),
        .active_count (active_count),
        .hit_pulse    (hit_pulse),
        .hit_count    (hit_count),
        .expire_pulse (expire_pulse),
        .wrong_pulse  (wrong_pulse),
        .spawn_ms     (spawn_ms)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step(input int k = 1);
        repeat (k) @(posedge clk);
        #1;
    endtask

    initial begin
        enable = 1'b1;
        level  = 2'd0;
        #12;
        chk("rst_moles", 32'(moles), 0);
        chk("rst_active", 32'(active_count), 0);
        chk("rst_spawn_ms", 32'(spawn_ms), 0);
        chk("rst_hit_pulse", 32'(hit_pulse), 0);
        chk("rst_expire", 32'(expire_pulse), 0);
        chk("rst_wrong", 32'(wrong_pulse), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // first mole after 1500 ticks at level 0
        n = 0;
        while (moles == 2'b00 && n < 6100) begin step(); n++; end
        chk("t1_latency_ok", 32'(n >= 5990 && n <= 6020), 1);
        chk("t1_one_bit", 32'($countones(moles)), 1);
        chk("t1_active", 32'(active_count), 1);
        m1 = moles;
        level = 2'd3;

        // second spawn 300 ticks later; probe must land on the free hole
        n = 0;
        while (active_count != 2'd2 && n < 1300) begin step(); n++; end
        chk("t5_latency_ok", 32'(n >= 1190 && n <= 1215), 1);
        chk("t5_both_lit", 32'(moles), 3);

        // interval expiry at MAX_ACTIVE: skipped, reloaded, nothing spawned
        step(1240);
        chk("t4_active", 32'(active_count), 2);
        chk("t4_moles", 32'(moles), 3);
        chk("t4_reload_ok", 32'(spawn_ms >= 286 && spawn_ms <= 296), 1);

        // level-3 mole expires 500 ticks after its spawn
        n = 0;
        while (!expire_pulse && n < 1000) begin step(); n++; end
        el = 1240 + n;
        chk("t2_expire_seen", 32'(expire_pulse), 1);
        chk("t2_expire_time_ok", 32'(el >= 1990 && el <= 2010), 1);
        chk("t2_moles_left", 32'(moles), 32'(m1));
        step();
        chk("t2_expire_once", 32'(expire_pulse), 0);
        chk("t2_moles_hold", 32'(moles), 32'(m1));

        // double hit
        n = 0;
        while (active_count != 2'd2 && n < 600) begin step(); n++; end
        chk("t3_pre_both", 32'(moles), 3);
        hit = 2'b11;
        step();
        hit = 2'b00;
        chk("t3_moles_clr", 32'(moles), 0);
        chk("t3_hit_pulse", 32'(hit_pulse), 1);
        chk("t3_hit_count", 32'(hit_count), 2);
        chk("t3_no_expire", 32'(expire_pulse), 0);
        step();
        chk("t3_pulse_drop", 32'(hit_pulse), 0);
        chk("t3_count_drop", 32'(hit_count), 0);

        // hit on an unlit hole
        hit = 2'b01;
        step();
        hit = 2'b00;
`ifdef MOLE_SPAWNER_WRONG_HIT_EN
        chk("wrong_pulse", 32'(wrong_pulse), 1);
`else
        chk("wrong_pulse", 32'(wrong_pulse), 0);
`endif
        chk("wrong_no_hit", 32'(hit_pulse), 0);
        step();
        chk("wrong_once", 32'(wrong_pulse), 0);

        // enable low clears everything without pulses
        n = 0;
        while (active_count != 2'd2 && n < 3000) begin step(); n++; end
        chk("en_pre_both", 32'(moles), 3);
        enable = 1'b0;
        step();
        chk("en_moles", 32'(moles), 0);
        chk("en_active", 32'(active_count), 0);
        chk("en_no_expire", 32'(expire_pulse), 0);
        chk("en_no_hit", 32'(hit_pulse), 0);
        step(3);
        enable = 1'b1;
        n = 0;
        while (moles == 2'b00 && n < 1300) begin step(); n++; end
        chk("en_restart_ok", 32'(n >= 1190 && n <= 1215), 1);

        // async reset mid-WAIT with moles lit
        n = 0;
        while (active_count != 2'd2 && n < 1400) begin step(); n++; end
        chk("r_pre_both", 32'(moles), 3);
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("r_moles", 32'(moles), 0);
        chk("r_active", 32'(active_count), 0);
        chk("r_spawn_ms", 32'(spawn_ms), 0);
        chk("r_expire", 32'(expire_pulse), 0);
        chk("r_hit_pulse", 32'(hit_pulse), 0);
        #20;
        rst_n = 1'b1;
        step(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
